mandel_point_scheduler: RTL and testbench
=========================================

# mandel_point_scheduler

Frame-level scheduler that shares a bank of `NUM_PG` point generators across every pixel of a Mandelbrot frame. It scans pixel coordinates in raster order and issues one-cycle `start` pulses to idle generators. It holds each generator's `x`/`y` stable while that generator iterates, collects finished iteration counts, and serialises them onto a single framebuffer write port with backpressure. It sits between the frame-request logic and the array of point generator instances.

## Interface
Parameters:
- `NUM_PG`, 4: number of point generator instances scheduled (1..16).
- `HBI`, 32: iteration count width, matching the generators' `max_iterations`/`iteration`.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle request to render a frame; ignored unless `busy` is 0.
- `width`  in  12  pixels per line; latched on accepted `frame_start`.
- `height`  in  12  lines per frame; latched on accepted `frame_start`.
- `busy`  out  1  high from the cycle after an accepted `frame_start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse when the last result has been written.
- `pg_start`  out  NUM_PG  one-hot start pulse per generator.
- `pg_x`  out  12*NUM_PG  per-generator x coordinate; slice i is bits [12i+11:12i].
- `pg_y`  out  12*NUM_PG  per-generator y coordinate; same slicing as `pg_x`.
- `pg_ready`  in  NUM_PG  per-generator ready (idle) flag.
- `pg_iteration`  in  HBI*NUM_PG  per-generator result, valid while that generator is ready.
- `wr_valid`  out  1  framebuffer write request.
- `wr_ready`  in  1  framebuffer accepts a write when high together with `wr_valid`.
- `wr_x`, `wr_y`  out  12 each  pixel address of the write.
- `wr_data`  out  HBI  iteration count to store.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: accepted `frame_start` latches `width`/`height`, clears the scan counters `sx`/`sy` to 0, and moves to RUN.
  - If `width` or `height` is 0, go straight to DONE.
- Per-generator flags:
  - `inflight[i]`: set when `pg_start[i]` is issued.
  - `seen_low[i]`: set once `pg_ready[i]` is sampled 0 while `inflight[i]` is set.
  - `pending[i]`: set on the first cycle where `inflight[i] && seen_low[i] && pg_ready[i]`; at the same time `inflight[i]` and `seen_low[i]` clear.
  - A ready level seen before ready has dropped never counts as completion.
- Generator i is free when `inflight[i]` and `pending[i]` are both 0. A generator is never restarted before its result has been written.
- Dispatch (RUN only):
  - At most one start per cycle, to the lowest-index free generator.
  - Registered: `pg_start[i]` is high for exactly one cycle, with `pg_x`/`pg_y` slice i updated to (`sx`, `sy`) in that same cycle.
  - Slice i then holds until the next dispatch to generator i.
  - After each dispatch, `sx` increments. When `sx == width-1`, `sx` wraps to 0 and `sy` increments.
  - Dispatching pixel (`width-1`, `height-1`) moves the FSM to DRAIN.
- Write-back:
  - When `wr_valid` is 0 and any `pending` bit is set, select the lowest-index pending generator j.
  - Register `wr_valid=1`, `wr_x`/`wr_y` = slice j of `pg_x`/`pg_y`, and `wr_data` = slice j of `pg_iteration`.
  - All write outputs hold stable until `wr_valid && wr_ready`. On that handshake, `pending[j]` clears and `wr_valid` drops for at least one cycle.
  - Write-back runs in RUN and DRAIN; dispatch and write-back are independent in the same cycle.
- DRAIN: wait until every `inflight`, `pending` and `wr_valid` is 0, then go to DONE.
- DONE: pulse `frame_done` for one cycle, then go to IDLE.
- `frame_start` is ignored in every state except IDLE.
- Reset (`RST_N` low, any time including mid-frame):
  - FSM returns to IDLE; all flags and counters clear.
  - All outputs go to 0: `busy`, `frame_done`, `pg_start`, `pg_x`, `pg_y`, `wr_valid`, `wr_x`, `wr_y`, `wr_data`.
  - In-flight generator results are discarded.

## Timing
- Cycle 0: `frame_start` high in IDLE. Cycle 1: RUN, `busy`=1. Cycle 2: first `pg_start[0]`, for pixel (0,0).
- With all generators free, `pg_start` goes to generators 0,1,...,NUM_PG-1 on consecutive cycles.
- With the current generators (ready low 1 cycle after start, high 2 cycles after start), `pending[i]` sets 3 cycles after `pg_start[i]`, and `wr_valid` rises on the following cycle.
- Write throughput is at most one write per two cycles.
- `frame_done` follows the final write handshake by exactly 2 cycles (DRAIN→DONE transition, then the pulse). `busy` drops in the cycle after `frame_done`.
- Writes may leave in completion order, not raster order; every pixel is written exactly once.

## Test plan
- Basic frame: `NUM_PG`=4, 4×2 frame, fixed 2-cycle generator model, `wr_ready`=1 → exactly 8 writes covering (0..3, 0..1), each with the model's iteration value, then one `frame_done`; `busy` is low afterwards.
- Late ready drop: generator holds ready high for 3 cycles after start before dropping → no write occurs until ready falls and rises again; the written value is the final `pg_iteration`.
- Simultaneous completion plus backpressure: generators 1 and 2 finish in the same cycle, `wr_ready` low for 5 cycles → generator 1's write is held stable for 5 cycles, then generator 2's write follows; neither generator is restarted before its own write.
- Degenerate size: `width`=0, `height`=5 → no `pg_start`, no writes, `frame_done` 2 cycles after `frame_start`. Also 1×1 frame → one write at (0,0).
- Line wrap: `width`=3, `height`=3 → dispatch order is (0,0)(1,0)(2,0)(0,1)…(2,2); a `frame_start` pulsed mid-frame is ignored.
- Reset mid-frame: assert `RST_N` low during RUN with 2 generators in flight → all outputs are 0 immediately; after release, a new `frame_start` renders a full frame correctly.

Source files
------------

// File: rtl/mandel_point_scheduler.sv
// Mandelbrot frame scheduler: raster-scans pixels onto a bank of point generators
// and serialises their finished iteration counts onto a single framebuffer write port.
module mandel_point_scheduler #(
    parameter int NUM_PG = 4,
    parameter int HBI    = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  frame_start,
    input  logic [11:0]           width,
    input  logic [11:0]           height,
    output logic                  busy,
    output logic                  frame_done,
    output logic [NUM_PG-1:0]     pg_start,
    output logic [12*NUM_PG-1:0]  pg_x,
    output logic [12*NUM_PG-1:0]  pg_y,
    input  logic [NUM_PG-1:0]     pg_ready,
    input  logic [HBI*NUM_PG-1:0] pg_iteration,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [11:0]           wr_x,
    output logic [11:0]           wr_y,
    output logic [HBI-1:0]        wr_data
);
    // state | meaning
    // IDLE  | waiting for an accepted frame_start
    // RUN   | dispatching pixels and writing back results
    // DRAIN | every pixel dispatched, waiting for the remaining results
    // DONE  | one-cycle frame_done pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int IW = (NUM_PG > 1) ? $clog2(NUM_PG) : 1;

    state_t            state, state_nxt;
    logic [11:0]       width_q, height_q, sx, sy;
    logic [NUM_PG-1:0] inflight, seen_low, pending;
    logic [IW-1:0]     disp_idx, pend_idx, wr_sel;
    logic              disp_any, pend_any, disp_fire, last_pixel, zero_size, wr_fire, wb_en;

    // Lowest-index free generator and lowest-index pending result.
    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = NUM_PG - 1; i >= 0; i--) begin
            if (!inflight[i] && !pending[i]) begin
                disp_any = 1'b1;
                disp_idx = IW'(i);
            end
            if (pending[i]) begin
                pend_any = 1'b1;
                pend_idx = IW'(i);
            end
        end
    end

    assign zero_size  = (width_q == 12'd0) || (height_q == 12'd0);
    assign last_pixel = (sx == width_q - 12'd1) && (sy == height_q - 12'd1);
    assign disp_fire  = (state == RUN) && !zero_size && disp_any;
    assign wr_fire    = wr_valid && wr_ready;
    assign wb_en      = (state == RUN) || (state == DRAIN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN: begin
                if (zero_size)                    state_nxt = DONE;
                else if (disp_fire && last_pixel) state_nxt = DRAIN;
            end
            DRAIN:   if (inflight == '0 && pending == '0 && !wr_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            width_q  <= '0;
            height_q <= '0;
            sx       <= '0;
            sy       <= '0;
            pg_start <= '0;
            pg_x     <= '0;
            pg_y     <= '0;
            inflight <= '0;
            seen_low <= '0;
            pending  <= '0;
            wr_valid <= 1'b0;
            wr_sel   <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_data  <= '0;
        end else begin
            pg_start <= '0;
            if (state == IDLE && frame_start) begin
                width_q  <= width;
                height_q <= height;
                sx       <= '0;
                sy       <= '0;
            end
            if (disp_fire) begin
                pg_start[disp_idx]            <= 1'b1;
                pg_x[12*int'(disp_idx) +: 12] <= sx;
                pg_y[12*int'(disp_idx) +: 12] <= sy;
                if (sx == width_q - 12'd1) begin
                    sx <= '0;
                    sy <= sy + 12'd1;
                end else begin
                    sx <= sx + 12'd1;
                end
            end
            // Completion needs ready to have dropped first; a stale idle level never counts.
            for (int i = 0; i < NUM_PG; i++) begin
                if (disp_fire && disp_idx == IW'(i)) begin
                    inflight[i] <= 1'b1;
                end else if (inflight[i] && seen_low[i] && pg_ready[i]) begin
                    pending[i]  <= 1'b1;
                    inflight[i] <= 1'b0;
                    seen_low[i] <= 1'b0;
                end else if (inflight[i] && !pg_ready[i]) begin
                    seen_low[i] <= 1'b1;
                end
                if (wr_fire && wr_sel == IW'(i)) pending[i] <= 1'b0;
            end
            if (wr_valid) begin
                if (wr_ready) wr_valid <= 1'b0;
            end else if (wb_en && pend_any) begin
                wr_valid <= 1'b1;
                wr_sel   <= pend_idx;
                wr_x     <= pg_x[12*int'(pend_idx) +: 12];
                wr_y     <= pg_y[12*int'(pend_idx) +: 12];
                wr_data  <= pg_iteration[HBI*int'(pend_idx) +: HBI];
            end
        end
    end
endmodule

// File: tb/tb_mandel_point_scheduler.sv
// Bench for mandel_point_scheduler: generator stand-ins, raster-order dispatch queue
// and a pixel-keyed write scoreboard checked by an independent monitor.
module tb_mandel_point_scheduler;
    localparam int NUM_PG = 4;
    localparam int HBI    = 32;

    logic                  CLK = 1'b0;
    logic                  RST_N = 1'b0;
    logic                  frame_start = 1'b0;
    logic [11:0]           width = '0, height = '0;
    logic                  busy, frame_done, wr_valid;
    logic                  wr_ready = 1'b1;
    logic [NUM_PG-1:0]     pg_start, pg_ready;
    logic [12*NUM_PG-1:0]  pg_x, pg_y;
    logic [HBI*NUM_PG-1:0] pg_iteration;
    logic [11:0]           wr_x, wr_y;
    logic [HBI-1:0]        wr_data;

    mandel_point_scheduler #(.NUM_PG(NUM_PG), .HBI(HBI)) dut (
        .CLK(CLK), .RST_N(RST_N), .frame_start(frame_start), .width(width), .height(height),
        .busy(busy), .frame_done(frame_done), .pg_start(pg_start), .pg_x(pg_x), .pg_y(pg_y),
        .pg_ready(pg_ready), .pg_iteration(pg_iteration), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] seed = 32'h1234_5678;

    // generator stand-in configuration
    int pre[NUM_PG], dur[NUM_PG], age[NUM_PG];
    bit act[NUM_PG];
    logic [31:0] res[NUM_PG];

    // scoreboard and per-frame observations
    int          disp_q[$];
    logic [31:0] exp_val[int];
    int          gen_of[int];
    bit          owed[NUM_PG];
    int          disp_gen[$], disp_cyc[$], wr_order[$];
    int          start_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0, nwr = 0;
    int          done_cnt = 0, max_stall = 0, stall_cur = 0;
    int          rdy_mode = 0, stall_left = 0;
    bit          stall_done = 0;

    task automatic chk(input string name, input longint act_v, input longint exp_v);
        n_chk++;
        if (act_v != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] pix_val(input int x, input int y);
        return seed ^ (32'(x) * 32'd131 + 32'(y) * 32'd7919 + 32'd17);
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Generator stand-ins: ready stays high 'pre' cycles, low 'dur' cycles, then high with result.
    initial begin
        pg_ready     = '1;
        pg_iteration = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < NUM_PG; i++) begin
                if (!RST_N) begin
                    act[i]      = 0;
                    pg_ready[i] = 1'b1;
                end else if (pg_start[i]) begin
                    act[i] = 1;
                    age[i] = 0;
                    res[i] = pix_val(int'(pg_x[12*i +: 12]), int'(pg_y[12*i +: 12]));
                    pg_iteration[HBI*i +: HBI] = 32'hBAD0_0000 | 32'(i);
                end else if (act[i]) begin
                    age[i]++;
                    if (age[i] <= pre[i]) pg_ready[i] = 1'b1;
                    else if (age[i] <= pre[i] + dur[i]) pg_ready[i] = 1'b0;
                    else begin
                        pg_ready[i] = 1'b1;
                        pg_iteration[HBI*i +: HBI] = res[i];
                        act[i] = 0;
                    end
                end
            end
        end
    end

    // Framebuffer backpressure: 0 always ready, 1 random, 2 one 5-cycle stall on the first write.
    initial forever begin
        @(posedge CLK);
        #1;
        case (rdy_mode)
            1: wr_ready = 1'($urandom_range(0, 1));
            2: begin
                if (wr_valid && !stall_done && stall_left == 0) begin
                    stall_left = 5;
                    stall_done = 1;
                end
                if (stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                end else wr_ready = 1'b1;
            end
            default: wr_ready = 1'b1;
        endcase
    end

    // Monitor
    initial begin
        bit          prev_valid, prev_hs;
        logic [55:0] prev_word;
        int          key, exp_k;
        prev_valid = 0;
        prev_hs    = 0;
        prev_word  = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_valid = 0;
                prev_hs    = 0;
            end else begin
                if (pg_start != '0) chk("start_onehot", $countones(pg_start), 1);
                for (int i = 0; i < NUM_PG; i++) begin
                    if (pg_start[i]) begin
                        key = int'({pg_y[12*i +: 12], pg_x[12*i +: 12]});
                        chk("start_expected", int'(disp_q.size() != 0), 1);
                        if (disp_q.size() != 0) begin
                            exp_k = disp_q.pop_front();
                            chk("dispatch_xy", key, exp_k);
                        end
                        chk("restart_before_write", owed[i], 0);
                        owed[i]     = 1;
                        gen_of[key] = i;
                        disp_gen.push_back(i);
                        disp_cyc.push_back(cyc - start_cyc);
                    end
                end
                if (prev_hs) chk("valid_gap", wr_valid, 0);
                if (prev_valid && !prev_hs) begin
                    chk("valid_held", wr_valid, 1);
                    chk("wr_hold", {wr_x, wr_y, wr_data}, prev_word);
                end
                if (wr_valid) begin
                    if (first_valid_cyc < 0) first_valid_cyc = cyc - start_cyc;
                    if (!wr_ready) begin
                        stall_cur++;
                        if (stall_cur > max_stall) max_stall = stall_cur;
                    end else begin
                        key = int'({wr_y, wr_x});
                        chk("write_expected", int'(exp_val.exists(key)), 1);
                        if (exp_val.exists(key)) begin
                            chk("wr_data", wr_data, exp_val[key]);
                            exp_val.delete(key);
                            if (gen_of.exists(key)) owed[gen_of[key]] = 0;
                        end
                        wr_order.push_back(key);
                        last_hs_cyc = cyc;
                        nwr++;
                        stall_cur = 0;
                    end
                end
                prev_valid = wr_valid;
                prev_hs    = wr_valid && wr_ready;
                prev_word  = {wr_x, wr_y, wr_data};
                if (frame_done) begin
                    done_cnt++;
                    if (nwr > 0) chk("done_after_last_write", cyc - last_hs_cyc, 2);
                    else         chk("done_latency_empty", cyc - start_cyc, 2);
                end
            end
        end
    end

    task automatic clear_sb();
        disp_q.delete();
        exp_val.delete();
        gen_of.delete();
        disp_gen.delete();
        disp_cyc.delete();
        wr_order.delete();
        for (int i = 0; i < NUM_PG; i++) owed[i] = 0;
        nwr = 0; max_stall = 0; stall_cur = 0; first_valid_cyc = -1; stall_done = 0; last_hs_cyc = 0;
    endtask

    task automatic set_gens(input int p, input int d);
        for (int i = 0; i < NUM_PG; i++) begin
            pre[i] = p;
            dur[i] = d;
        end
    endtask

    task automatic start_frame(input int w, input int h);
        @(posedge CLK);
        #1;
        clear_sb();
        seed = $urandom;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                disp_q.push_back((y << 12) | x);
                exp_val[(y << 12) | x] = pix_val(x, y);
            end
        start_cyc   = cyc;
        frame_start = 1'b1;
        width       = 12'(w);
        height      = 12'(h);
        @(posedge CLK);
        #1;
        frame_start = 1'b0;
        width       = 12'($urandom);
        height      = 12'($urandom);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, frame_done, pg_start, wr_valid}, 0);
        chk({tag, "_pg_x"}, pg_x, 0);
        chk({tag, "_pg_y"}, pg_y, 0);
        chk({tag, "_wr"}, {wr_x, wr_y, wr_data}, 0);
    endtask

    task automatic wait_done(input int budget);
        int t0, n;
        t0 = done_cnt;
        n  = 0;
        while (done_cnt == t0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        #1;
        chk("frame_done_seen", int'(done_cnt != t0), 1);
        if (done_cnt == t0) begin
            RST_N = 1'b0;
            clear_sb();
            @(posedge CLK);
            #1;
            RST_N = 1'b1;
        end else begin
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", frame_done, 0);
            chk("all_pixels_written", exp_val.num(), 0);
            chk("all_dispatched", disp_q.size(), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_gens(0, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk_zero("reset");
        RST_N = 1'b1;

        // basic 4x2 frame
        start_frame(4, 2);
        wait_done(500);
        chk("basic_writes", nwr, 8);
        chk("basic_first_valid", first_valid_cyc, 6);
        chk("basic_dispatches", disp_gen.size(), 8);
        for (int k = 0; k < 4; k++)
            if (k < disp_gen.size()) begin
                chk("basic_disp_gen", disp_gen[k], k);
                chk("basic_disp_cycle", disp_cyc[k], 2 + k);
            end

        // late ready drop on a 1x1 frame
        pre[0] = 3;
        dur[0] = 2;
        start_frame(1, 1);
        wait_done(500);
        chk("late_writes", nwr, 1);
        chk("late_first_valid", first_valid_cyc, 10);

        // generators 1 and 2 finish together, 5-cycle stall on the first write
        set_gens(0, 1);
        dur[0] = 20; dur[1] = 2; dur[2] = 1; dur[3] = 3;
        rdy_mode = 2;
        start_frame(6, 1);
        wait_done(500);
        chk("bp_writes", nwr, 6);
        chk("bp_stall", max_stall, 5);
        if (wr_order.size() >= 2) begin
            chk("bp_first_write", wr_order[0], 1);
            chk("bp_second_write", wr_order[1], 2);
        end

        // degenerate sizes
        rdy_mode = 0;
        set_gens(0, 1);
        start_frame(0, 5);
        wait_done(50);
        chk("zero_w_writes", nwr, 0);
        chk("zero_w_starts", disp_gen.size(), 0);
        start_frame(1, 1);
        wait_done(100);
        chk("one_px_writes", nwr, 1);

        // line wrap with an ignored mid-frame request
        start_frame(3, 3);
        @(posedge CLK);
        #1;
        frame_start = 1'b1;
        width = 12'd7;
        height = 12'd7;
        @(posedge CLK);
        #1;
        frame_start = 1'b0;
        wait_done(500);
        chk("wrap_writes", nwr, 9);

        // reset mid-frame with two generators in flight
        set_gens(0, 10);
        start_frame(8, 4);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        chk("second_dispatch", pg_start, 2);
        RST_N = 1'b0;
        #1;
        chk_zero("midrst");
        clear_sb();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        set_gens(0, 2);
        start_frame(5, 3);
        wait_done(1000);
        chk("after_rst_writes", nwr, 15);

        // randomized frames
        for (int k = 0; k < 8; k++) begin
            rdy_mode = $urandom_range(0, 1);
            for (int i = 0; i < NUM_PG; i++) begin
                dur[i] = $urandom_range(1, 5);
                pre[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            start_frame($urandom_range(1, 6), $urandom_range(1, 5));
            wait_done(3000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
